// File: rtl/lc3_run_ctrl_pkg.sv
// Shared types for the LC-3 run controller: FSM state enum and default counter width.
package lc3_tb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    RELEASE,
    RUN,
    DONE
  } run_state_e;

  localparam int unsigned CNT_W_DEFAULT = 32;

endpackage

// File: rtl/lc3_run_ctrl_if.sv
// Control/status bundle between the run controller and whoever launches a run.
// progress/stall exist only when LC3_RUN_CTRL_STALL_DET_EN is defined.
interface lc3_run_ctrl_if
  import lc3_tb_pkg::*;
#(
  parameter int unsigned NUM_DOM = 2,
  parameter int unsigned CNT_W   = CNT_W_DEFAULT
) ();

  logic               start;
  logic               halt_in;
  logic [CNT_W-1:0]   budget;
  logic [NUM_DOM-1:0] dom_rst_n;
  logic               running;
  logic               done;
  logic               timeout;
  logic [CNT_W-1:0]   cycle_cnt;
`ifdef LC3_RUN_CTRL_STALL_DET_EN
  logic               progress;
  logic               stall;

  modport master (output start, halt_in, budget, progress,
                  input  dom_rst_n, running, done, timeout, cycle_cnt, stall);
  modport slave  (input  start, halt_in, budget, progress,
                  output dom_rst_n, running, done, timeout, cycle_cnt, stall);
`else
  modport master (output start, halt_in, budget,
                  input  dom_rst_n, running, done, timeout, cycle_cnt);
  modport slave  (input  start, halt_in, budget,
                  output dom_rst_n, running, done, timeout, cycle_cnt);
`endif

endinterface

// File: rtl/lc3_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module lc3_sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/lc3_run_ctrl.sv
// Run controller: holds DUT reset domains, releases them staggered, then times the run
// until halt or budget expiry. Stall detection is built when LC3_RUN_CTRL_STALL_DET_EN is defined.
module lc3_run_ctrl
  import lc3_tb_pkg::*;
#(
  parameter int unsigned NUM_DOM  = 2,
  parameter int unsigned HOLD_CYC = 2,
  parameter int unsigned STAGGER  = 1,
  parameter int unsigned CNT_W    = CNT_W_DEFAULT
`ifdef LC3_RUN_CTRL_STALL_DET_EN
  ,
  parameter int unsigned STALL_CYC = 64
`endif
) (
  input logic           clk,
  input logic           rst,
  lc3_run_ctrl_if.slave bus
);

  localparam int unsigned PH_W     = 8;
  localparam int unsigned REL_LAST = STAGGER * (NUM_DOM - 1);

  run_state_e         state, state_n;
  logic [PH_W-1:0]    phase, phase_n;
  logic [CNT_W-1:0]   budget_q, budget_n;
  logic [NUM_DOM-1:0] dom_n;
  logic               timeout_n;
  logic               start_acc;
  logic               budget_hit;
`ifdef LC3_RUN_CTRL_STALL_DET_EN
  localparam int unsigned ST_W = $clog2(STALL_CYC + 1);
  logic [ST_W-1:0]    stall_cnt;
  logic               stall_n;
  logic               stall_hit;
`endif

  // Domains whose release offset has been reached k cycles after RELEASE entry.
  function automatic logic [NUM_DOM-1:0] rel_mask(input logic [PH_W-1:0] k);
    logic [NUM_DOM-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NUM_DOM; i++) m[i] = (PH_W'(STAGGER * i) <= k);
    return m;
  endfunction

  lc3_sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .clr (start_acc),
    .en  (state == RUN),
    .cnt (bus.cycle_cnt)
  );

`ifdef LC3_RUN_CTRL_STALL_DET_EN
  // Held at zero outside RUN so each run starts with a fresh count.
  lc3_sat_counter #(.W(ST_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (bus.progress || (state != RUN)),
    .en  (state == RUN),
    .cnt (stall_cnt)
  );
  assign stall_hit = !bus.progress && (stall_cnt == ST_W'(STALL_CYC - 1));
`endif

  assign budget_hit = (budget_q != '0) && (bus.cycle_cnt == budget_q - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    phase_n   = phase;
    budget_n  = budget_q;
    dom_n     = bus.dom_rst_n;
    timeout_n = bus.timeout;
    start_acc = 1'b0;
`ifdef LC3_RUN_CTRL_STALL_DET_EN
    stall_n   = bus.stall;
`endif
    unique case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_n   = HOLD;
          phase_n   = '0;
          budget_n  = bus.budget;
          dom_n     = '0;
          timeout_n = 1'b0;
          start_acc = 1'b1;
`ifdef LC3_RUN_CTRL_STALL_DET_EN
          stall_n   = 1'b0;
`endif
        end
      end
      HOLD: begin
        if (phase == PH_W'(HOLD_CYC - 1)) begin
          state_n = RELEASE;
          phase_n = '0;
          dom_n   = rel_mask('0);
        end else begin
          phase_n = phase + PH_W'(1);
        end
      end
      RELEASE: begin
        if (phase == PH_W'(REL_LAST)) begin
          state_n = RUN;
        end else begin
          phase_n = phase + PH_W'(1);
          dom_n   = rel_mask(phase + PH_W'(1));
        end
      end
      RUN: begin
        // Priority: halt, then stall, then budget expiry.
        if (bus.halt_in) begin
          state_n = DONE;
`ifdef LC3_RUN_CTRL_STALL_DET_EN
        end else if (stall_hit) begin
          state_n = DONE;
          stall_n = 1'b1;
`endif
        end else if (budget_hit) begin
          state_n   = DONE;
          timeout_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase         <= '0;
      budget_q      <= '0;
      bus.dom_rst_n <= '0;
      bus.running   <= 1'b0;
      bus.done      <= 1'b0;
      bus.timeout   <= 1'b0;
`ifdef LC3_RUN_CTRL_STALL_DET_EN
      bus.stall     <= 1'b0;
`endif
    end else begin
      phase         <= phase_n;
      budget_q      <= budget_n;
      bus.dom_rst_n <= dom_n;
      bus.running   <= (state_n == RUN);
      bus.done      <= (state_n == DONE);
      bus.timeout   <= timeout_n;
`ifdef LC3_RUN_CTRL_STALL_DET_EN
      bus.stall     <= stall_n;
`endif
    end
  end

endmodule

// File: doc/lc3_run_ctrl.md
LC3_RUN_CTRL -- requirements
Module: lc3_run_ctrl

Interface
REQ-001 Parameter NUM_DOM, default 2: number of independently released DUT reset domains, range 1-4.
REQ-002 Parameter HOLD_CYC, default 2: cycles all domains are held in reset after start, range 1-255.
REQ-003 Parameter STAGGER, default 1: cycles between consecutive domain releases, range 0-15.
REQ-004 Parameter CNT_W, default 32: width of the cycle counter and budget.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  single-cycle run request.
REQ-008 halt_in  in  1  DUT halt indication, e.g. HALT trap, sampled each cycle.
REQ-009 budget  in  CNT_W  maximum RUN cycles; 0 means unlimited; sampled on accepted start.
REQ-010 dom_rst_n  out  NUM_DOM  active-low resets to DUT domains; bit i is domain i.
REQ-011 running  out  1  high while in RUN.
REQ-012 done  out  1  high in DONE.
REQ-013 timeout  out  1  high in DONE when the budget expired.
REQ-014 cycle_cnt  out  CNT_W  RUN cycles elapsed.

Function
REQ-015 FSM states shall be IDLE, HOLD, RELEASE, RUN and DONE.
REQ-016 IDLE: all dom_rst_n=0; start shall go to HOLD, latch budget and clear cycle_cnt.
REQ-017 HOLD shall last exactly HOLD_CYC cycles with all dom_rst_n=0, then go to RELEASE.
REQ-018 RELEASE: domain i shall go high STAGGER*i cycles after RELEASE entry; the FSM shall go to RUN in the cycle after domain NUM_DOM-1 is released.
REQ-019 With STAGGER=0, all domains shall release in the same cycle; RELEASE shall last one cycle.
REQ-020 RUN: cycle_cnt shall increment by 1 per cycle and saturate at all-ones.
REQ-021 RUN: halt_in=1 shall go to DONE next cycle with done=1, timeout=0.
REQ-022 RUN: when budget!=0 and cycle_cnt==budget-1, the FSM shall go to DONE with timeout=1.
REQ-023 If halt and budget expiry coincide, halt shall win: timeout=0.
REQ-024 halt_in shall be ignored outside RUN.
REQ-025 DONE: dom_rst_n shall stay high and cycle_cnt shall freeze; start shall re-enter HOLD, clearing done and timeout and driving all dom_rst_n low.
REQ-026 start shall be ignored in HOLD, RELEASE and RUN.

Reset
REQ-027 rst shall force IDLE, dom_rst_n=0, running=0, done=0, timeout=0 and cycle_cnt=0 next edge, from any state, including mid-RELEASE.
REQ-028 rst shall take precedence over start and halt_in in the same cycle.

Configuration
REQ-029 Macro LC3_RUN_CTRL_STALL_DET_EN defined: add parameter STALL_CYC (default 64), input progress (1 bit, e.g. instruction retire) and output stall (1 bit).
REQ-030 With the macro, STALL_CYC consecutive RUN cycles without progress shall go to DONE with stall=1, timeout=0; halt takes priority over stall, and stall over timeout.
REQ-031 With the macro, the stall counter shall clear on progress, on entering RUN and on rst.
REQ-032 Without the macro, the progress and stall ports, the stall counter and the stall logic shall be absent, and behaviour shall be per REQ-015..028.

Structure
REQ-033 Package lc3_tb_pkg shall hold the run_state_e enum (IDLE/HOLD/RELEASE/RUN/DONE) and the default CNT_W constant.
REQ-034 A sub-module lc3_sat_counter (parametrised width, clear, enable, saturating) shall implement cycle_cnt and the stall counter.

Verification
REQ-035 Defaults, start at cycle 5 -> dom_rst_n=00 for 2 cycles, bit0 high, bit1 high one cycle later, then running=1.
REQ-036 budget=10, no halt -> DONE after exactly 10 RUN cycles, cycle_cnt=10, timeout=1.
REQ-037 budget=10, halt_in in the 10th RUN cycle -> done=1, timeout=0.
REQ-038 NUM_DOM=4, STAGGER=3 -> releases at +0, +3, +6, +9 cycles; rst asserted at +4 -> dom_rst_n=0000 and IDLE next cycle.
REQ-039 In DONE, start -> done=0, dom_rst_n all low for HOLD_CYC cycles, cycle_cnt=0.
REQ-040 Macro defined, STALL_CYC=8, progress held low, budget=0 -> stall=1, done=1 after 8 RUN cycles.
